// File: rtl/alu_seq.sv
// alu_seq: a sequential ALU with a valid/ready handshake on both sides.
// Arithmetic and logic ops finish in one cycle. Shifts move one bit per
// cycle, and the first bit moves on the accept edge, so a shift by N
// delivers its result N cycles after accept.
module alu_seq #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] inA_i,
  input  logic [XLEN-1:0] inB_i,
  output logic [XLEN-1:0] out_o,
  output logic            cflag_o,
  output logic            vflag_o,
  output logic            zflag_o,
  output logic            nflag_o,
  output logic            valid_o,
  input  logic            ready_i
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam int               MSB = XLEN - 1;
  localparam logic [SHW-1:0]   CNT_ZERO = '0;
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   work_q;
  logic [SHW-1:0]    cnt_q;
  logic [3:0]        sop_q;
  logic [XLEN-1:0]   out_q;
  logic              c_q, v_q, z_q, n_q, valid_q;

  logic [XLEN:0]     add_full;
  logic [XLEN:0]     sub_full;
  logic              add_v, sub_v;
  logic [XLEN-1:0]   alu_res;
  logic              alu_c, alu_v;
  logic              is_shift;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   shift_src;
  logic [3:0]        shift_op;
  logic [XLEN-1:0]   shift_nxt;

  // One-bit shift step; the op code selects the direction and the fill bit.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      OP_SRA:  r = {v[MSB], v[XLEN-1:1]};
      default: r = {1'b0, v[XLEN-1:1]};
    endcase
    return r;
  endfunction

  // The extra top bit holds the carry out; SUB is A + ~B + 1, so its carry
  // out is the "no borrow" flag.
  assign add_full = {1'b0, inA_i} + {1'b0, inB_i};
  assign sub_full = {1'b0, inA_i} + {1'b0, ~inB_i} + {{XLEN{1'b0}}, 1'b1};
  assign add_v    = inA_i[MSB] ^ inB_i[MSB] ^ add_full[MSB] ^ add_full[XLEN];
  assign sub_v    = (inA_i[MSB] != inB_i[MSB]) && (sub_full[MSB] != inA_i[MSB]);

  assign is_shift = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);
  assign shamt    = inB_i[SHW-1:0];

  // The shifter works on the operand at accept and on the working register
  // after that.
  assign shift_src = (state_q == S_IDLE) ? inA_i : work_q;
  assign shift_op  = (state_q == S_IDLE) ? op_i  : sop_q;
  assign shift_nxt = shift_one(shift_op, shift_src);

  // Single-cycle result for the non-shift ops; undefined codes give zero.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_i)
      OP_ADD:  begin alu_res = add_full[XLEN-1:0]; alu_c = add_full[XLEN]; alu_v = add_v; end
      OP_SUB:  begin alu_res = sub_full[XLEN-1:0]; alu_c = sub_full[XLEN]; alu_v = sub_v; end
      OP_AND:  alu_res = inA_i & inB_i;
      OP_OR:   alu_res = inA_i | inB_i;
      OP_XOR:  alu_res = inA_i ^ inB_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(inA_i) < $signed(inB_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (inA_i < inB_i)};
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered result and flags; reset aborts any operation.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            if (!is_shift) begin
              out_q   <= alu_res;
              c_q     <= alu_c;
              v_q     <= alu_v;
              z_q     <= (alu_res == '0);
              n_q     <= alu_res[MSB];
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else if (shamt == CNT_ZERO) begin
              out_q   <= inA_i;
              c_q     <= 1'b0;
              v_q     <= 1'b0;
              z_q     <= (inA_i == '0);
              n_q     <= inA_i[MSB];
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else if (shamt == CNT_ONE) begin
              out_q   <= shift_nxt;
              c_q     <= 1'b0;
              v_q     <= 1'b0;
              z_q     <= (shift_nxt == '0);
              n_q     <= shift_nxt[MSB];
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              work_q  <= shift_nxt;
              cnt_q   <= shamt - CNT_ONE;
              sop_q   <= op_i;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (cnt_q == CNT_ONE) begin
            out_q   <= shift_nxt;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= (shift_nxt == '0);
            n_q     <= shift_nxt[MSB];
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            work_q <= shift_nxt;
            cnt_q  <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = valid_q;
  assign out_o   = out_q;
  assign cflag_o = c_q;
  assign vflag_o = v_q;
  assign zflag_o = z_q;
  assign nflag_o = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at XLEN=64 with hand-computed expectations.
module tb_alu_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_i;
  logic [63:0] inA_i, inB_i;
  logic [63:0] out_o;
  logic        cflag_o, vflag_o, zflag_o, nflag_o;
  logic        valid_o;
  logic        ready_i;

  int n_total = 0;
  int n_bad   = 0;

  alu_seq #(.XLEN(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .inA_i(inA_i), .inB_i(inB_i), .out_o(out_o),
    .cflag_o(cflag_o), .vflag_o(vflag_o), .zflag_o(zflag_o), .nflag_o(nflag_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {cflag_o, vflag_o, zflag_o, nflag_o};
  endfunction

  // Issue one request and wait (bounded) for valid_o; counts cycles from accept.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic rdy_seen);
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; inA_i = a; inB_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!valid_o && lat < 200) begin
      if (ready_o) rdy_seen = 1'b1;
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic release_res(input string tag);
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk({tag, "_rel_valid"}, {63'd0, valid_o}, 64'd0);
    chk({tag, "_rel_ready"}, {63'd0, ready_o}, 64'd1);
    ready_i = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_out,
                          input logic [3:0] exp_flags, input int exp_lat, input bit do_release);
    int lat;
    logic rdy_seen;
    run_op(op, a, b, lat, rdy_seen);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_out"}, out_o, exp_out);
    chk({tag, "_cvzn"}, {60'd0, flags()}, {60'd0, exp_flags});
    chk({tag, "_busy"}, {63'd0, rdy_seen}, 64'd0);
    if (do_release) release_res(tag);
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; inA_i = '0; inB_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_out", out_o, 64'd0);
    chk("rst_flags", {60'd0, flags()}, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Flags are {c,v,z,n}
    check_op("add_ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101, 1, 1);
    check_op("sub_eq",  4'd1, 64'd5, 64'd5, 64'd0, 4'b1010, 1, 1);
    check_op("sub_neg", 4'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 1, 1);
    check_op("sub_ovf", 4'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100, 1, 1);
    check_op("and", 4'd2, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1, 1);
    check_op("or",  4'd3, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000, 1, 1);
    check_op("xor", 4'd4, 64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000, 1, 1);
    check_op("undef", 4'd12, 64'd5, 64'd5, 64'd0, 4'b0010, 1, 1);
    check_op("sra63", 4'd9, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 63, 1);
    check_op("sll0", 4'd7, 64'h1234, 64'd0, 64'h1234, 4'b0000, 1, 1);
    check_op("sltu", 4'd6, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 1, 1);
    check_op("slt",  4'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0010, 1, 1);
    check_op("sll4", 4'd7, 64'd1, 64'h104, 64'h10, 4'b0000, 4, 1);
    check_op("srl4", 4'd8, 64'hF0, 64'd4, 64'h0F, 4'b0000, 4, 1);
    check_op("sll1", 4'd7, 64'd3, 64'd1, 64'd6, 4'b0000, 1, 1);
    check_op("sra2", 4'd9, 64'h4000_0000_0000_0000, 64'd2, 64'h1000_0000_0000_0000, 4'b0000, 2, 1);

    // Result held in DONE while the producer side keeps changing
    check_op("add_ff", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, 4'b1001, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      valid_i = ~valid_i;
      op_i = 4'(i);
      inA_i = {$urandom, $urandom};
      inB_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
      chk("hold_out", out_o, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("hold_flags", {60'd0, flags()}, 64'b1001);
      chk("hold_valid", {63'd0, valid_o}, 64'd1);
      chk("hold_ready", {63'd0, ready_o}, 64'd0);
    end
    valid_i = 1'b0;
    release_res("hold");

    // Reset in the middle of a 40-bit shift
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 4'd7; inA_i = 64'd1; inB_i = 64'd40;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #2;
    chk("mid_busy", {63'd0, ready_o}, 64'd0);
    reset_i = 1'b1;
    #1;
    chk("abort_ready", {63'd0, ready_o}, 64'd1);
    chk("abort_valid", {63'd0, valid_o}, 64'd0);
    chk("abort_out", out_o, 64'd0);
    chk("abort_flags", {60'd0, flags()}, 64'd0);
    @(posedge clk_i); #1;
    chk("abort_valid2", {63'd0, valid_o}, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    check_op("add_post", 4'd0, 64'd2, 64'd3, 64'd5, 4'b0000, 1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
